// File: rtl/lsu_dmem_master.sv
// Load/store unit data-memory master: one RV32I load or store at a time onto the L1 data bus.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_dmem_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd,
  output logic [3:0]  dmem_mask,
  input  logic [31:0] dmem_rd,
  input  logic        dmem_wait,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready; req_valid
  // may be raised at any time and the request fields must be stable while it waits. The bus
  // holds dmem_req with stable addr/wd/mask until a cycle with dmem_wait=0 completes it.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_ready;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_reject;
  logic        w_done;
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_store_wd;
  logic [3:0]  w_mask;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept    = req_valid & w_ready;
  assign w_done      = (r_state == S_ACCESS) & ~dmem_wait;
  assign w_lane      = r_addr[1:0];
  assign o_dbg_state = r_state;

  always_comb begin
    w_illegal = 1'b0;
    if (req_we) w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else        w_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                      ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject = w_illegal | w_misalign;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a rejected request skips the bus and answers straight away
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_reject ? S_RESP : S_ACCESS;
      S_ACCESS: if (!dmem_wait) w_next = S_RESP;
      S_RESP:   begin
        if (w_accept) w_next = w_reject ? S_RESP : S_ACCESS;
        else          w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_resp_data <= 32'd0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      if (w_reject) begin
        r_resp_data <= 32'd0;
        r_resp_err  <= 1'b1;
      end
    end else if (w_done) begin
      r_resp_data <= r_we ? 32'd0 : w_load_data;
      r_resp_err  <= 1'b0;
    end
  end

  // Load extraction from the word returned on the bus
  always_comb begin
    w_byte = dmem_rd[7:0];
    case (w_lane)
      2'd1:    w_byte = dmem_rd[15:8];
      2'd2:    w_byte = dmem_rd[23:16];
      2'd3:    w_byte = dmem_rd[31:24];
      default: w_byte = dmem_rd[7:0];
    endcase
    w_half      = r_addr[1] ? dmem_rd[31:16] : dmem_rd[15:0];
    w_load_data = dmem_rd;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rd;
    endcase
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    w_mask     = 4'b1111;
    w_store_wd = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_mask     = 4'b0001 << w_lane;
        w_store_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_mask     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_store_wd = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask     = 4'b1111;
        w_store_wd = r_wdata;
      end
    endcase
  end

  // Outputs; reset masks everything so an abandoned access never strobes
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 32'd0;
    resp_err   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_wd    = 32'd0;
    dmem_mask  = 4'b0000;
    if (!reset) begin
      req_ready  = w_ready;
      resp_valid = (r_state == S_RESP);
      resp_data  = r_resp_data;
      resp_err   = r_resp_err;
      if (r_state == S_ACCESS) begin
        dmem_req  = 1'b1;
        dmem_we   = r_we & ~dmem_wait;
        dmem_addr = {r_addr[31:2], 2'b00};
        dmem_wd   = r_we ? w_store_wd : 32'd0;
        dmem_mask = w_mask;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: transaction-level model, bus responder and per-cycle scoreboard.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_rd;
  logic        dmem_wait;
  logic [1:0]  dbg_state;

  lsu_dmem_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wd(dmem_wd), .dmem_mask(dmem_mask),
    .dmem_rd(dmem_rd), .dmem_wait(dmem_wait), .o_dbg_state(dbg_state)
  );

  // Clock / cycle counter: cyc is the number of rising edges seen so far
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: plain arithmetic on size and byte offset
  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int op_off(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    return (a / op_size(f3)) * op_size(f3);
  endfunction

  function automatic bit is_reject(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit ill;
    bit mis;
    if (we) ill = !(f3 == 0 || f3 == 1 || f3 == 2);
    else    ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis = (addr % op_size(f3)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) ill = 1'b1;
`else
    if (mis && 0) ill = 1'b1;
`endif
    return ill;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    longint unsigned v;
    int sz;
    sz = op_size(f3);
    v  = longint'(rd) >> (8 * op_off(f3, addr));
    v  = v % (64'd1 << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= op_off(f3, addr) && i < op_off(f3, addr) + op_size(f3)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % op_size(f3)) +: 8];
    return r;
  endfunction

  // Scoreboard state
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  mask;
    logic        we;
    int          nwait;
  } bus_t;

  bus_t        bus_q[$];
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  int          resp_log[$];
  int          start_log[$];
  bus_t        cur_b;
  logic [32:0] cur_e;
  int          cur_c;
  int          we_pulses = 0;
  int          resp_count = 0;
  int          bus_ops = 0;
  int          bus_cnt = 0;
  int          cur_start = 0;
  int          last_acc = 0;
  int          last_resp_cyc = 0;
  int          last_req_cycles = 0;
  logic [31:0] last_resp_data = '0;
  logic        last_resp_err = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wd = '0;
  logic [3:0]  last_mask = '0;

  // Bus responder: inserts the op's wait cycles and returns its read word
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (dmem_req && bus_q.size() > 0) begin
      dmem_rd = bus_q[0].rd;
      if (wcnt < bus_q[0].nwait) begin
        dmem_wait = 1'b1;
        wcnt++;
      end else begin
        dmem_wait = 1'b0;
        wcnt = 0;
      end
    end else begin
      dmem_wait = 1'b0;
      wcnt = 0;
    end
  end

  // Compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (dmem_we) we_pulses++;
    if (reset) begin
      chk("reset_ctrl", {req_ready, resp_valid, resp_err, dmem_req, dmem_we, dmem_mask}, 64'd0);
      chk("reset_addr", dmem_addr, 64'd0);
      chk("reset_data", {resp_data, dmem_wd}, 64'd0);
      bus_cnt = 0;
    end else begin
      chk("ready_vs_req", req_ready, !dmem_req);
      if (!dmem_req) chk("idle_strobes", {dmem_we, dmem_mask}, 64'd0);
      else if (bus_q.size() == 0) chk("unexpected_req", dmem_req, 64'd0);
      else begin
        cur_b = bus_q[0];
        if (bus_cnt == 0) cur_start = cyc;
        bus_cnt++;
        chk("bus_addr", dmem_addr, cur_b.addr);
        if (cur_b.we) begin
          chk("bus_mask", dmem_mask, cur_b.mask);
          chk("bus_wd", dmem_wd, cur_b.wd);
        end
        if (dmem_wait) chk("we_during_wait", dmem_we, 64'd0);
        else begin
          chk("we_on_done", dmem_we, cur_b.we);
          chk("bus_cycles", bus_cnt, cur_b.nwait + 1);
          last_addr = dmem_addr;
          last_mask = dmem_mask;
          last_wd = dmem_wd;
          last_req_cycles = bus_cnt;
          start_log.push_back(cur_start);
          bus_ops++;
          bus_cnt = 0;
          void'(bus_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_resp", resp_valid, 64'd0);
        else begin
          cur_e = exp_q.pop_front();
          cur_c = exp_cyc_q.pop_front();
          chk("resp_err_data", {resp_err, resp_data}, cur_e);
          chk("resp_cycle", cyc, cur_c);
          last_resp_data = resp_data;
          last_resp_err = resp_err;
          last_resp_cyc = cyc;
          resp_log.push_back(cyc);
          resp_count++;
        end
      end
    end
  end

  // Driver: called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input int nwait);
    bus_t b;
    int   n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 64'd1);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (is_reject(we, f3, addr)) begin
      exp_q.push_back({1'b1, 32'd0});
      exp_cyc_q.push_back(last_acc);
    end else begin
      b.addr  = addr & 32'hFFFF_FFFC;
      b.we    = we;
      b.mask  = model_mask(f3, addr);
      b.wd    = model_wd(f3, wdata);
      b.rd    = rd;
      b.nwait = nwait;
      bus_q.push_back(b);
      exp_q.push_back({1'b0, we ? 32'd0 : model_load(f3, addr, rd)});
      exp_cyc_q.push_back(last_acc + 1 + nwait);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size() + bus_q.size(), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: stuck at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  int acc;
  int w0;
  int r0;
  int a2;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; dmem_rd = '0; dmem_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 64'd1);
    @(posedge clk);
    #1;

    // SW 0x100: single strobe; response two cycles after the request cycle (one edge after accept)
    w0 = we_pulses;
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 0);
    acc = last_acc;
    wait_done();
    chk("sw_we_pulses", we_pulses - w0, 64'd1);
    chk("sw_mask", last_mask, 64'hF);
    chk("sw_wd", last_wd, 64'hDEADBEEF);
    chk("sw_err", last_resp_err, 64'd0);
    chk("sw_latency", last_resp_cyc - acc, 64'd1);

    issue(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 0);
    wait_done();
    chk("lb_data", last_resp_data, 64'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 0);
    wait_done();
    chk("lbu_data", last_resp_data, 64'h00000080);

    // SH with three wait cycles
    w0 = we_pulses;
    issue(1'b1, 3'b001, 32'h202, 32'h1234, 32'd0, 3);
    wait_done();
    chk("sh_req_cycles", last_req_cycles, 64'd4);
    chk("sh_addr", last_addr, 64'h200);
    chk("sh_mask", last_mask, 64'hC);
    chk("sh_wd", last_wd, 64'h12341234);
    chk("sh_we_pulses", we_pulses - w0, 64'd1);

    // Misaligned LW
    r0 = bus_ops;
    issue(1'b0, 3'b010, 32'h301, 32'd0, 32'hCAFEBABE, 0);
    acc = last_acc;
    wait_done();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", last_resp_err, 64'd1);
    chk("lw_mis_nobus", bus_ops - r0, 64'd0);
    chk("lw_mis_latency", last_resp_cyc - acc, 64'd0);
`else
    chk("lw_mis_err", last_resp_err, 64'd0);
    chk("lw_mis_addr", last_addr, 64'h300);
    chk("lw_mis_data", last_resp_data, 64'hCAFEBABE);
`endif

    // Illegal funct3 codes
    r0 = bus_ops;
    issue(1'b0, 3'b011, 32'h20, 32'd0, 32'd0, 0);
    issue(1'b0, 3'b110, 32'h20, 32'd0, 32'd0, 0);
    issue(1'b0, 3'b111, 32'h20, 32'd0, 32'd0, 0);
    issue(1'b1, 3'b100, 32'h24, 32'h1, 32'd0, 0);
    issue(1'b1, 3'b011, 32'h24, 32'h1, 32'd0, 0);
    wait_done();
    chk("illegal_err", last_resp_err, 64'd1);
    chk("illegal_nobus", bus_ops - r0, 64'd0);

    // Back-to-back: second op presented while the first is outstanding
    issue(1'b0, 3'b010, 32'h10, 32'd0, 32'h11223344, 0);
    issue(1'b1, 3'b010, 32'h14, 32'h55667788, 32'd0, 0);
    a2 = last_acc;
    wait_done();
    chk("b2b_accept_in_resp", a2, resp_log[resp_log.size() - 2] + 1);
    chk("b2b_req_next", start_log[start_log.size() - 1], resp_log[resp_log.size() - 2] + 1);

    // Width/sign corners
    issue(1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_7FFF, 1);
    wait_done();
    chk("lh_data", last_resp_data, 64'hFFFF8001);
    issue(1'b0, 3'b101, 32'h100, 32'd0, 32'h8001_7FFF, 0);
    wait_done();
    chk("lhu_data", last_resp_data, 64'h00007FFF);
    issue(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'd0, 2);
    wait_done();
    chk("sb_mask", last_mask, 64'h8);
    chk("sb_wd", last_wd, 64'hA5A5A5A5);
    issue(1'b0, 3'b000, 32'h101, 32'd0, 32'h0000_7F00, 0);
    issue(1'b0, 3'b101, 32'h103, 32'd0, 32'hF00D_1234, 0);
    issue(1'b1, 3'b001, 32'h101, 32'h0000_BEEF, 32'd0, 1);
    issue(1'b0, 3'b010, 32'h3FC, 32'd0, 32'h0BAD_F00D, $urandom_range(0, 3));
    wait_done();

    // Reset during a waited store
    w0 = we_pulses;
    r0 = resp_count;
    issue(1'b1, 3'b001, 32'h40, 32'h0000_BEEF, 32'd0, 6);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    bus_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", req_ready, 64'd1);
    repeat (3) @(negedge clk);
    chk("midreset_no_we", we_pulses - w0, 64'd0);
    chk("midreset_no_resp", resp_count - r0, 64'd0);
    @(posedge clk);
    #1;

    issue(1'b0, 3'b010, 32'h44, 32'd0, 32'h600D_CAFE, 0);
    wait_done();
    chk("post_reset_lw", last_resp_data, 64'h600DCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: req_valid  in  1  pipeline memory-op request.
REQ-004 SHALL have ports: req_we  in  1  1=store, 0=load.
REQ-005 SHALL have ports: req_funct3  in  3  RV32I width/sign code.
REQ-006 SHALL have ports: req_addr  in  32  byte address.
REQ-007 SHALL have ports: req_wdata  in  32  store data (low bits significant).
REQ-008 SHALL have ports: req_ready  out  1  request accepted on the edge where req_valid&req_ready.
REQ-009 SHALL have ports: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: resp_data  out  32  extended load data, 0 for stores.
REQ-011 SHALL have ports: resp_err  out  1  illegal/misaligned op, qualified by resp_valid.
REQ-012 SHALL have ports: dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wd  out  32 each; dmem_mask  out  4; dmem_rd  in  32; dmem_wait  in  1. These are the data-side initiator of the L1 bus.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP. req_ready=1 in IDLE and RESP. An accepted request registers all req_* fields and enters ACCESS. A rejected request (illegal funct3 or trap) enters RESP directly with resp_err=1 and no bus activity.
REQ-014 SHALL, in ACCESS, drive dmem_req=1 and hold dmem_addr={addr[31:2],2'b00}, dmem_wd and dmem_mask stable until completion.
REQ-015 SHALL complete an access in the first ACCESS cycle with dmem_wait=0. dmem_we=store&~dmem_wait, so exactly one write strobe occurs per store.
REQ-016 SHALL, for a load, capture the extended dmem_rd into resp_data on the completing edge.
REQ-017 SHALL assert resp_valid=1 for exactly the RESP cycle. From RESP: next state is ACCESS if a new request is accepted, otherwise IDLE.
REQ-018 SHALL set latency (no wait) as: accept at edge N, dmem_req high cycle N+1, resp_valid cycle N+2. Each wait cycle adds 1. Peak throughput is 1 op per 2 cycles.
REQ-019 SHALL use lane = addr[1:0]. Mask/data rules:
  - SB (000): mask=1<<lane, wd=byte replicated x4.
  - SH (001): mask=0011 if addr[1]=0 else 1100, wd=halfword replicated x2.
  - SW (010): mask=1111, wd=req_wdata.
REQ-020 SHALL extract load data as follows:
  - LB/LBU (000/100): byte at lane, sign-/zero-extended.
  - LH/LHU (001/101): half at addr[1], sign-/zero-extended.
  - LW (010): full word.
REQ-021 SHALL treat as illegal: load funct3 011, 110, 111, and store funct3 other than 000, 001, 010.
REQ-022 SHALL drive dmem_req=0, dmem_we=0 and dmem_mask=0000 outside ACCESS.

Reset
REQ-023 SHALL, while reset=1, force state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wd=0, dmem_mask=0. req_ready=1 from the first cycle after reset deasserts.
REQ-024 SHALL, when reset is asserted mid-ACCESS, abandon the op: no write strobe in any cycle with reset=1, and no resp_valid.

Configuration
REQ-025 SHALL support macro LSU_MISALIGN_TRAP_EN.
  - Defined: a halfword op with addr[0]=1, or a word op with addr[1:0]!=00, is rejected per REQ-013 with resp_err=1.
  - Undefined: misalignment is ignored. Word ops use addr[31:2]; halfword ops use addr[1] only; resp_err is set only for illegal funct3.

Verification
REQ-026 SW addr=0x100 wdata=0xDEADBEEF, dmem_wait=0 -> one cycle with dmem_we=1, mask=1111, wd=0xDEADBEEF; resp_valid 2 cycles after accept with resp_err=0.
REQ-027 LB addr=0x103, dmem_rd=0x80FF_0000 -> resp_data=0xFFFFFF80. LBU, same inputs -> resp_data=0x00000080.
REQ-028 SH addr=0x202 wdata=0x1234 with dmem_wait=1 for 3 cycles -> dmem_req held 4 cycles with stable addr 0x200, mask=1100, wd=0x12341234; dmem_we high only in the 4th cycle.
REQ-029 LW addr=0x301 with LSU_MISALIGN_TRAP_EN -> no dmem_req, resp_valid with resp_err=1 one cycle after accept. Without the macro -> access at 0x300, resp_err=0.
REQ-030 Back-to-back LW 0x10 then SW 0x14, second presented during RESP -> second accepted in RESP, dmem_req re-asserted the next cycle.
REQ-031 Reset asserted during a waited store -> no dmem_we pulse and no resp_valid; all outputs 0; req_ready=1 the cycle after reset drops.
